qam16_mapper: RTL
=================

Name: qam16_mapper

Overview:
- Hard-decision 16QAM mapper (modulator). It is the transmit-side counterpart of the 16QAM demapper.
- Accepts a serial bit stream and groups it MSB-first into 4-bit symbols. Each symbol is Gray-mapped to a signed 8-bit I/Q constellation point.
- Symbols are buffered in a 2-entry FIFO and presented on a valid/ready output interface to the DAC/pulse-shaping stage.

Parameters:
- LEVEL_1, 32: magnitude of the inner constellation level (±1 point). Signed 8-bit; must be in 1..127.
- LEVEL_3, 96: magnitude of the outer constellation level (±3 point). Must be > LEVEL_1 and ≤ 127.

Ports:
- dclk  in  1  data/symbol clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  mapper enable. While low, incoming bits are ignored; the FIFO still drains.
- flush  in  1  synchronous clear of any partially collected symbol. FIFO contents are kept.
- data_in  in  1  serial data bit.
- bit_valid  in  1  data_in is valid this cycle.
- bit_ready  out  1  mapper can accept a bit this cycle.
- I_out  out  8  signed in-phase value of the FIFO head.
- Q_out  out  8  signed quadrature value of the FIFO head.
- sym_valid  out  1  FIFO head holds a valid symbol.
- sym_ready  in  1  downstream accepts the symbol this cycle.

Behaviour:
- One clock; reset is asynchronous, active-high, on ports dclk / rst.
- Reset values:
  - bit counter = 0, shift register = 0, FIFO empty.
  - sym_valid = 0, I_out = Q_out = 0.
  - bit_ready = 1.
- Bit accept: a bit is accepted when bit_valid & bit_ready & en & !flush.
- bit_ready:
  - Combinational: bit_ready = !(cnt == 3 && fifo_count == 2).
  - It does not depend on sym_ready, so there is no combinational ready path through the block.
- Collection FSM:
  - States COLLECT0..COLLECT3, encoded as a 2-bit counter cnt.
  - The first accepted bit is b3; each accepted bit shifts in at the LSB side.
  - On the 4th accepted bit (cnt == 3), symbol {b3,b2,b1,b0} is formed from the 3 stored bits plus data_in. It is pushed into the FIFO at the same edge, and cnt wraps to 0.
- Gray map:
  - I is taken from {b3,b2}; Q is taken from {b1,b0}.
  - 00 → −LEVEL_3, 01 → −LEVEL_1, 11 → +LEVEL_1, 10 → +LEVEL_3.
  - Mapping is done before the FIFO write, so the FIFO stores 8-bit I and Q per entry.
- Latency:
  - 4th bit accepted at edge N with the FIFO empty → sym_valid = 1 with the correct I_out/Q_out immediately after edge N.
  - Sustained throughput is 1 symbol per 4 bit cycles.
- Output handshake:
  - The FIFO head is popped at an edge where sym_valid & sym_ready.
  - While sym_valid = 1 and sym_ready = 0, I_out/Q_out/sym_valid hold stable.
  - When the FIFO is empty, sym_valid = 0 and I_out = Q_out = 0.
- FIFO (depth 2):
  - Simultaneous push and pop at count 1: count stays 1, and the new head is the pushed symbol.
  - Push at count 2 cannot occur, because bit_ready blocks it.
  - Pop at count 0 is ignored.
  - FIFO order is strictly preserved.
- en low: cnt and the shift register hold (partial symbol retained). Output side is unaffected.
- flush: cnt → 0 and the shift register is cleared at the edge. A bit presented in the flush cycle is dropped. flush has priority over bit accept.
- Reset mid-operation: the partial symbol and all FIFO entries are discarded; outputs return to reset values asynchronously.

Test Plan:
- Reset, then bits 1,0,0,1 on consecutive cycles with sym_ready = 1:
  - After the 4th edge: sym_valid = 1, I_out = +96, Q_out = −32.
  - sym_valid drops one cycle later.
- All 16 symbols 0000..1111 back-to-back with sym_ready = 1:
  - 0000 → (−96, −96), 1111 → (+32, +32), 1010 → (+96, +96), 0101 → (−32, −32).
  - All 16 points match the Gray table.
- sym_ready held 0, 12 bits offered:
  - After 8 bits, 2 symbols are queued and cnt reaches 3 after 3 more bits.
  - bit_ready = 0 from then on. The 12th bit stalls until sym_ready pulses, after which both symbols drain in order.
- Bits 1,1 then flush = 1 with bit_valid = 1, then bits 0,0,0,0:
  - Exactly one symbol is produced: (−96, −96). The flushed bit is dropped.
- en = 0 for 5 cycles between the 2nd and 3rd bits of symbol 0111:
  - Output is (−32, +32) after the 4th accepted bit; no bits are consumed while en = 0.
- rst asserted asynchronously with 2 symbols queued and cnt = 2:
  - sym_valid, I_out and Q_out go to 0 immediately; bit_ready = 1.
  - The next 4 bits form a fresh symbol.

Source files
------------

// File: rtl/qam16_mapper.sv
// qam16_mapper: serial-to-16QAM Gray mapper with a 2-entry output FIFO.
// Bits arrive MSB-first. Every 4 accepted bits form a symbol, which is
// Gray-mapped to signed 8-bit I/Q values. The symbol then waits in a small FIFO
// on a valid/ready interface. bit_ready depends only on registered state, so
// there is no combinational path from sym_ready to bit_ready.
module qam16_mapper #(
  parameter int LEVEL_1 = 32,
  parameter int LEVEL_3 = 96
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic       en,
  input  logic       flush,
  input  logic       data_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [7:0] I_out,
  output logic [7:0] Q_out,
  output logic       sym_valid,
  input  logic       sym_ready
);

  localparam logic signed [7:0] L1 = LEVEL_1[7:0];
  localparam logic signed [7:0] L3 = LEVEL_3[7:0];

  // Gray map of one axis: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3
  function automatic logic signed [7:0] gray_map(input logic [1:0] b);
    logic signed [7:0] v;
    case (b)
      2'b00:   v = -L3;
      2'b01:   v = -L1;
      2'b11:   v = L1;
      default: v = L3;
    endcase
    return v;
  endfunction

  logic [1:0]        r_cnt;      // bits already held for the current symbol
  logic [2:0]        r_shift;    // stored b3..b1, newest bit at the LSB
  logic [1:0]        r_count;    // FIFO occupancy, 0..2
  logic signed [7:0] r_i0, r_q0; // FIFO head
  logic signed [7:0] r_i1, r_q1; // FIFO second entry

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [3:0]        w_sym;
  logic signed [7:0] w_new_i;
  logic signed [7:0] w_new_q;

  assign bit_ready = !(r_cnt == 2'd3 && r_count == 2'd2);
  assign sym_valid = (r_count != 2'd0);
  assign w_accept  = bit_valid & bit_ready & en & ~flush;
  assign w_push    = w_accept & (r_cnt == 2'd3);
  assign w_pop     = sym_valid & sym_ready;
  assign w_sym     = {r_shift, data_in};
  assign w_new_i   = gray_map(w_sym[3:2]);
  assign w_new_q   = gray_map(w_sym[1:0]);

  // Empty FIFO shows zeros so the DAC sees silence rather than stale data.
  assign I_out = sym_valid ? r_i0 : 8'sd0;
  assign Q_out = sym_valid ? r_q0 : 8'sd0;

  // Bit collection counter and shift register. flush takes priority over accept.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 2'd0;
      r_shift <= 3'd0;
    end else if (flush) begin
      r_cnt   <= 2'd0;
      r_shift <= 3'd0;
    end else if (w_accept) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {r_shift[1:0], data_in};
    end
  end

  // FIFO occupancy. A push together with a pop leaves the count unchanged.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage. A push at count 2 cannot happen because bit_ready blocks it.
  always_ff @(posedge dclk) begin
    if (w_push) begin
      if (r_count == 2'd0 || (r_count == 2'd1 && w_pop)) begin
        r_i0 <= w_new_i;
        r_q0 <= w_new_q;
      end else begin
        r_i1 <= w_new_i;
        r_q1 <= w_new_q;
      end
    end else if (w_pop && r_count == 2'd2) begin
      r_i0 <= r_i1;
      r_q0 <= r_q1;
    end
  end

endmodule
